// File: rtl/rf_trace.sv
// rf_trace: watches NREG registers for value changes and streams each change,
// stamped with the cycle count, as records over a valid/ready port.
module rf_trace #(
   parameter int WIDTH      = 32,
   parameter int NREG       = 8,
   parameter int CW         = 16,
   parameter int MAX_CYCLES = 1000,
   parameter int LW         = 8
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic [NREG*WIDTH-1:0]   rf,
   input  logic                    trace_en,
   output logic                    rec_valid,
   input  logic                    rec_ready,
   output logic [$clog2(NREG)-1:0] rec_idx,
   output logic [WIDTH-1:0]        rec_data,
   output logic [CW-1:0]           rec_cycle,
   output logic [LW-1:0]           lost_cnt,
   output logic                    done
);
   localparam int IW = $clog2(NREG);
   localparam int OW = $clog2(NREG + 1);
   localparam int SW = LW + OW;

   logic [NREG-1:0]            pend_vec;
   logic [NREG-1:0][WIDTH-1:0] hval_vec;
   logic [NREG-1:0][CW-1:0]    hstamp_vec;
   logic [NREG-1:0]            chg;
   logic [NREG-1:0]            move;
   logic [NREG-1:0]            ovw;

   logic             rec_valid_reg;
   logic [IW-1:0]    rec_idx_reg;
   logic [WIDTH-1:0] rec_data_reg;
   logic [CW-1:0]    rec_cycle_reg;
   logic [IW-1:0]    rr_reg;
   logic [CW-1:0]    cycle_reg;
   logic [LW-1:0]    lost_reg;
   logic             done_reg;

   logic             load;
   logic             found;
   logic [IW-1:0]    sel;
   logic [IW-1:0]    rr_next;
   logic [OW-1:0]    ovw_cnt;
   logic [SW-1:0]    lost_sum;
   logic [LW-1:0]    lost_next;

   assign load = ~rec_valid_reg | rec_ready;

   generate
      for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
         logic [WIDTH-1:0] cur;
         logic [WIDTH-1:0] snap_reg;
         logic [WIDTH-1:0] hval_reg;
         logic [CW-1:0]    hstamp_reg;
         logic             pend_reg;

         assign cur            = rf[gi*WIDTH +: WIDTH];
         assign chg[gi]        = (cur != snap_reg) & trace_en & ~done_reg;
         assign move[gi]       = load & found & (sel == IW'(gi));
         assign ovw[gi]        = chg[gi] & pend_reg & ~move[gi];
         assign pend_vec[gi]   = pend_reg;
         assign hval_vec[gi]   = hval_reg;
         assign hstamp_vec[gi] = hstamp_reg;

         // A change on a register leaving for the slot this edge re-arms it with the new value.
         always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
               snap_reg   <= '0;
               hval_reg   <= '0;
               hstamp_reg <= '0;
               pend_reg   <= 1'b0;
            end else begin
               snap_reg <= cur;
               if (chg[gi]) begin
                  pend_reg   <= 1'b1;
                  hval_reg   <= cur;
                  hstamp_reg <= cycle_reg;
               end else if (move[gi]) begin
                  pend_reg <= 1'b0;
               end
            end
         end
      end
   endgenerate

   // Round-robin pick: first pending register at or above rr, wrapping.
   always_comb begin
      logic [IW:0] j;
      found = 1'b0;
      sel   = '0;
      j     = '0;
      for (int k = 0; k < NREG; k++) begin
         j = {1'b0, rr_reg} + (IW+1)'(k);
         if (j >= (IW+1)'(NREG)) j = j - (IW+1)'(NREG);
         if (!found && pend_vec[j[IW-1:0]]) begin
            found = 1'b1;
            sel   = j[IW-1:0];
         end
      end
   end

   assign rr_next = (sel == IW'(NREG - 1)) ? '0 : sel + IW'(1);

   always_comb begin
      ovw_cnt = '0;
      for (int k = 0; k < NREG; k++) ovw_cnt = ovw_cnt + OW'(ovw[k]);
      lost_sum  = SW'(lost_reg) + SW'(ovw_cnt);
      lost_next = (lost_sum > SW'({LW{1'b1}})) ? {LW{1'b1}} : lost_sum[LW-1:0];
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         rec_valid_reg <= 1'b0;
         rec_idx_reg   <= '0;
         rec_data_reg  <= '0;
         rec_cycle_reg <= '0;
         rr_reg        <= '0;
         cycle_reg     <= '0;
         lost_reg      <= '0;
         done_reg      <= 1'b0;
      end else begin
         lost_reg <= lost_next;
         if (load) begin
            rec_valid_reg <= found;
            if (found) begin
               rec_idx_reg   <= sel;
               rec_data_reg  <= hval_vec[sel];
               rec_cycle_reg <= hstamp_vec[sel];
               rr_reg        <= rr_next;
            end
         end
         // Counter parks at MAX_CYCLES once done is set.
         if (!done_reg) begin
            cycle_reg <= cycle_reg + CW'(1);
            if (cycle_reg == CW'(MAX_CYCLES - 1)) done_reg <= 1'b1;
         end
      end
   end

   assign rec_valid = rec_valid_reg;
   assign rec_idx   = rec_idx_reg;
   assign rec_data  = rec_data_reg;
   assign rec_cycle = rec_cycle_reg;
   assign lost_cnt  = lost_reg;
   assign done      = done_reg;

endmodule

// File: tb/tb_rf_trace.sv
// Bench for rf_trace: directed scenarios plus random traffic against a
// behavioural model of change capture, round-robin draining and cycle limit.
module tb_rf_trace;
   localparam int N    = 8;
   localparam int W    = 32;
   localparam int CWID = 16;
   localparam int LWID = 8;
   localparam int MAXC = 1000;
   localparam int LMAX = 20;
   localparam int LSAT = 255;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            n_rst, trace_en, rec_ready, rec_valid, done;
   logic [W-1:0]    rf_a [N];
   logic [N*W-1:0]  rf;
   logic [2:0]      rec_idx;
   logic [W-1:0]    rec_data;
   logic [CWID-1:0] rec_cycle;
   logic [LWID-1:0] lost_cnt;

   logic            lim_rst, lim_en, lim_ready, lim_valid, lim_done;
   logic [W-1:0]    lim_rf_a [N];
   logic [N*W-1:0]  lim_rf;
   logic [2:0]      lim_idx;
   logic [W-1:0]    lim_data;
   logic [CWID-1:0] lim_cycle;
   logic [LWID-1:0] lim_lost;

   always_comb begin
      rf = '0;
      for (int i = 0; i < N; i++) rf[i*W +: W] = rf_a[i];
   end
   always_comb begin
      lim_rf = '0;
      for (int i = 0; i < N; i++) lim_rf[i*W +: W] = lim_rf_a[i];
   end

   rf_trace #(.WIDTH(W), .NREG(N), .CW(CWID), .MAX_CYCLES(MAXC), .LW(LWID)) u_dut (
      .clk(clk), .n_rst(n_rst), .rf(rf), .trace_en(trace_en),
      .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_idx(rec_idx),
      .rec_data(rec_data), .rec_cycle(rec_cycle), .lost_cnt(lost_cnt), .done(done)
   );

   rf_trace #(.WIDTH(W), .NREG(N), .CW(CWID), .MAX_CYCLES(LMAX), .LW(LWID)) u_lim (
      .clk(clk), .n_rst(lim_rst), .rf(lim_rf), .trace_en(lim_en),
      .rec_valid(lim_valid), .rec_ready(lim_ready), .rec_idx(lim_idx),
      .rec_data(lim_data), .rec_cycle(lim_cycle), .lost_cnt(lim_lost), .done(lim_done)
   );

   always @(posedge clk)
      if (n_rst && rec_valid && rec_ready)
         $display("record idx=%0d data=%08h cycle=%0d lost=%0d", rec_idx, rec_data, rec_cycle, lost_cnt);

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model: per-register pending record, one output slot, rr pointer.
   logic [W-1:0] m_snap [N];
   logic [W-1:0] m_hval [N];
   int           m_hstamp [N];
   bit           m_pend [N];
   bit           m_valid, m_done;
   int           m_idx, m_cyc, m_rr, m_cnt, m_lost;
   logic [W-1:0] m_data;

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_snap[i] = '0; m_hval[i] = '0; m_hstamp[i] = 0; m_pend[i] = 1'b0;
      end
      m_valid = 1'b0; m_idx = 0; m_data = '0; m_cyc = 0;
      m_rr = 0; m_cnt = 0; m_lost = 0; m_done = 1'b0;
   endtask

   // Slot transfer happens first, so a same-edge change on the departing
   // register finds it non-pending and is not counted as lost.
   task automatic model_edge();
      bit found;
      int sel;
      found = 1'b0;
      sel = 0;
      if (!m_valid || rec_ready) begin
         for (int k = 0; k < N; k++) begin
            if (!found && m_pend[(m_rr + k) % N]) begin
               found = 1'b1;
               sel = (m_rr + k) % N;
            end
         end
         m_valid = found;
         if (found) begin
            m_idx = sel; m_data = m_hval[sel]; m_cyc = m_hstamp[sel];
            m_pend[sel] = 1'b0;
            m_rr = (sel + 1) % N;
         end
      end
      for (int i = 0; i < N; i++) begin
         if (rf_a[i] != m_snap[i] && trace_en && !m_done) begin
            if (m_pend[i]) m_lost = (m_lost < LSAT) ? m_lost + 1 : LSAT;
            m_pend[i] = 1'b1; m_hval[i] = rf_a[i]; m_hstamp[i] = m_cnt;
         end
         m_snap[i] = rf_a[i];
      end
      if (!m_done) begin
         if (m_cnt == MAXC - 1) m_done = 1'b1;
         m_cnt++;
      end
   endtask

   task automatic check_main(input string tag);
      chk({tag, ".valid"}, 64'(rec_valid), 64'(m_valid));
      if (m_valid) begin
         chk({tag, ".idx"},   64'(rec_idx),   64'(m_idx));
         chk({tag, ".data"},  64'(rec_data),  64'(m_data));
         chk({tag, ".cycle"}, 64'(rec_cycle), 64'(m_cyc));
      end
      chk({tag, ".lost"}, 64'(lost_cnt), 64'(m_lost));
      chk({tag, ".done"}, 64'(done), 64'(m_done));
   endtask

   task automatic step(input string tag);
      model_edge();
      @(posedge clk);
      #1;
      check_main(tag);
   endtask

   task automatic do_reset();
      n_rst = 1'b0;
      #1;
      chk("rst.valid", 64'(rec_valid), 64'd0);
      chk("rst.idx",   64'(rec_idx),   64'd0);
      chk("rst.data",  64'(rec_data),  64'd0);
      chk("rst.cycle", 64'(rec_cycle), 64'd0);
      chk("rst.lost",  64'(lost_cnt),  64'd0);
      chk("rst.done",  64'(done),      64'd0);
      model_reset();
      n_rst = 1'b1;
   endtask

   initial begin
      n_rst = 1'b0; trace_en = 1'b1; rec_ready = 1'b1;
      lim_rst = 1'b0; lim_en = 1'b1; lim_ready = 1'b1;
      for (int i = 0; i < N; i++) begin
         rf_a[i] = '0;
         lim_rf_a[i] = '0;
      end
      model_reset();
      @(posedge clk);
      #1;
      do_reset();

      // Single change: stamp 5, record two edges later, exactly once.
      repeat (5) step("idle");
      rf_a[3] = 32'hAA;
      step("t1.e");
      chk("t1.early", 64'(rec_valid), 64'd0);
      step("t1.e1");
      chk("t1.valid", 64'(rec_valid), 64'd1);
      chk("t1.idx",   64'(rec_idx),   64'd3);
      chk("t1.data",  64'(rec_data),  64'hAA);
      chk("t1.cycle", 64'(rec_cycle), 64'd5);
      step("t1.e2");
      chk("t1.once", 64'(rec_valid), 64'd0);

      // Reset while a record is in the slot; non-zero rf at release is reported.
      rf_a[0] = 32'h77;
      step("t6.a");
      step("t6.b");
      chk("t6.busy", 64'(rec_valid), 64'd1);
      rf_a[3] = '0;
      do_reset();
      step("t6.rel");
      step("t6.rep");
      chk("t6.idx",   64'(rec_idx),   64'd0);
      chk("t6.data",  64'(rec_data),  64'h77);
      chk("t6.cycle", 64'(rec_cycle), 64'd0);
      step("t6.end");

      // Simultaneous changes drain in index order with a common stamp.
      rf_a[1] = 32'd1; rf_a[2] = 32'd2; rf_a[6] = 32'd6;
      step("t2.e");
      step("t2.r1");
      chk("t2.idx1", 64'(rec_idx), 64'd1);
      chk("t2.cyc1", 64'(rec_cycle), 64'd3);
      step("t2.r2");
      chk("t2.idx2", 64'(rec_idx), 64'd2);
      chk("t2.cyc2", 64'(rec_cycle), 64'd3);
      step("t2.r3");
      chk("t2.idx3", 64'(rec_idx), 64'd6);
      chk("t2.cyc3", 64'(rec_cycle), 64'd3);
      chk("t2.lost", 64'(lost_cnt), 64'd0);
      step("t2.end");

      // Backpressure and overwrite.
      rec_ready = 1'b0;
      rf_a[4] = 32'h11;
      step("t3.a");
      step("t3.b");
      chk("t3.slot", 64'(rec_data), 64'h11);
      rf_a[4] = 32'h22;
      step("t3.c");
      rf_a[4] = 32'h33;
      step("t3.d");
      chk("t3.lost", 64'(lost_cnt), 64'd1);
      chk("t3.hold", 64'(rec_data), 64'h11);
      rec_ready = 1'b1;
      step("t3.e");
      chk("t3.idx2",  64'(rec_idx),  64'd4);
      chk("t3.data2", 64'(rec_data), 64'h33);
      step("t3.end");
      chk("t3.empty", 64'(rec_valid), 64'd0);

      // Round-robin between regs 0 and 7, starting from rr=5.
      for (int k = 1; k <= 12; k++) begin
         rf_a[0] = rf_a[0] + 32'd1 + ($urandom % 100);
         rf_a[7] = rf_a[7] ^ (32'h1 << ($urandom % 32));
         step("t4");
         if (k >= 2) begin
            chk("t4.idx",  64'(rec_idx), (k % 2 == 0) ? 64'd7 : 64'd0);
            chk("t4.lost", 64'(lost_cnt), 64'(k));
         end
      end
      repeat (3) step("t4.drain");

      // Change while disabled is never reported.
      trace_en = 1'b0;
      rf_a[2] = 32'hDEAD;
      step("t5.off");
      step("t5.off");
      trace_en = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step("t5.on");
         chk("t5.none", 64'(rec_valid), 64'd0);
         chk("t5.lost", 64'(lost_cnt), 64'd12);
      end

      // Saturation of the lost counter under full backpressure.
      rec_ready = 1'b0;
      for (int k = 0; k < 40; k++) begin
         for (int i = 0; i < N; i++) rf_a[i] = rf_a[i] + 32'd1 + $urandom_range(0, 999);
         step("sat");
      end
      chk("sat.lost", 64'(lost_cnt), 64'(LSAT));
      rec_ready = 1'b1;
      repeat (12) step("sat.drain");

      // Random traffic with one mid-run reset.
      for (int s = 0; s < 500; s++) begin
         for (int i = 0; i < N; i++)
            if ($urandom % 4 == 0) rf_a[i] = ($urandom % 2 == 0) ? $urandom : 32'($urandom % 4);
         trace_en  = ($urandom % 8) != 0;
         rec_ready = ($urandom % 3) != 0;
         if (s == 250) do_reset();
         step("rnd");
      end

      // Cycle limit on the MAX_CYCLES=20 instance.
      #1;
      chk("lim.rst.done",  64'(lim_done),  64'd0);
      chk("lim.rst.valid", 64'(lim_valid), 64'd0);
      lim_rst = 1'b1;
      for (int e = 1; e <= 30; e++) begin
         if (e == 20) lim_rf_a[5] = 32'h99;
         if (e == 26) lim_rf_a[1] = 32'h42;
         @(posedge clk);
         #1;
         chk("lim.done", 64'(lim_done), (e >= 20) ? 64'd1 : 64'd0);
         if (e == 21) begin
            chk("lim.valid", 64'(lim_valid), 64'd1);
            chk("lim.idx",   64'(lim_idx),   64'd5);
            chk("lim.data",  64'(lim_data),  64'h99);
            chk("lim.cycle", 64'(lim_cycle), 64'd19);
         end else begin
            chk("lim.none", 64'(lim_valid), 64'd0);
         end
      end
      chk("lim.lost", 64'(lim_lost), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/rf_trace.md
# rf_trace

Parametrised register-file change tracer for the CPU simulation and bring-up flow. It watches NREG architectural registers of WIDTH bits each cycle, captures every value change with a cycle stamp, and streams the changes as records over a valid/ready port. It also provides a run-length limit that ends tracing after a fixed cycle count. It sits beside `cpu`, tapping its rf outputs, and feeds a trace sink (bench monitor or debug UART).

## Interface
- WIDTH, 32, bits per register
- NREG, 8, number of registers watched (2..32)
- CW, 16, cycle-stamp width
- MAX_CYCLES, 1000, cycle count at which tracing stops (must be < 2^CW)
- LW, 8, width of lost-update counter
- clk  in  1  clock, rising edge
- n_rst  in  1  asynchronous active-low reset
- rf  in  NREG*WIDTH  flat register vector; register i at bits [i*WIDTH +: WIDTH]
- trace_en  in  1  capture enable
- rec_valid  out  1  record available
- rec_ready  in  1  sink accepts record
- rec_idx  out  clog2(NREG)  register index of record
- rec_data  out  WIDTH  new register value
- rec_cycle  out  CW  cycle stamp of the change
- lost_cnt  out  LW  saturating count of overwritten (unreported) changes
- done  out  1  sticky; cycle limit reached

## Operation
- State: snapshot[NREG] (last sampled rf), pending[NREG] bit plus held value and stamp per register, one output slot, rr pointer, cycle_cnt, lost_cnt, done.
- Every edge: snapshot <= rf, independent of trace_en and done, so re-enable never reports stale differences.
- Change detect: chg[i] = (rf[i] != snapshot[i]) & trace_en & ~done.
- On chg[i]: pending[i] <= 1, held value <= rf[i], held stamp <= cycle_cnt.
- If chg[i] while pending[i]=1 and i is not being moved to the slot this edge: overwrite, lost_cnt += 1 (saturate at 2^LW-1). Multiple overwrites in one edge add their count, saturating.
- Slot load: when slot empty or (rec_valid & rec_ready), the first pending register scanning upward from rr with wrap is moved to the slot; its pending bit clears; rr <= index+1 (mod NREG). If no pending register exists, the slot empties (on handshake) or stays empty.
- Same-edge conflict: if reg i is moved to the slot and chg[i] also occurs, the slot gets the old held value, pending[i] stays 1 with the new value, and lost_cnt is not incremented.
- Slot holds rec_idx/rec_data/rec_cycle stable while rec_valid & ~rec_ready.
- cycle_cnt: increments each edge while ~done. done <= 1 on the edge where cycle_cnt == MAX_CYCLES-1. After that, cycle_cnt holds MAX_CYCLES and captures stop; already pending records still drain.

## Timing
- Reset (async, n_rst=0): snapshot, pending, slot all 0; rec_valid=0, rec_idx=0, rec_data=0, rec_cycle=0, lost_cnt=0, done=0, cycle_cnt=0, rr=0.
- Reset mid-operation discards all pending and slot contents immediately. Release is sampled at the next rising edge.
- Latency: rf change visible before edge E (stamp = cycle_cnt before E). Pending is set at E, slot is loaded at E+1, and rec_valid is high after E+1 (2 edges).
- Throughput: one record per cycle with rec_ready held high.
- Reset snapshot is 0, so non-zero rf values present at reset release are reported as changes on the first edge.
- rf is treated as synchronous to clk.

## Test plan
- Reset then single change: rf[3] 0 -> 0x0000_00AA before edge with cycle_cnt=5, rec_ready=1. Required: rec_valid after 2 edges with idx=3, data=0xAA, cycle=5, and exactly one record.
- Simultaneous changes: regs 1, 2, 6 change in one cycle, rr=0. Required: records idx 1, 2, 6 on three consecutive cycles, all with the same stamp, lost_cnt=0.
- Backpressure and overwrite: rec_ready=0; reg 4 changes to 0x11, then the slot fills; reg 4 changes to 0x22, then 0x33. Required: lost_cnt=1, and the second record seen after release carries 0x33.
- Round-robin fairness: regs 0 and 7 change every cycle, rec_ready=1. Required: records alternate idx 0/7, and lost_cnt grows for both.
- trace_en=0 during a change to reg 2, re-enabled with no further change. Required: no record and lost_cnt unchanged.
- Cycle limit with MAX_CYCLES=20: done rises after edge 20 and stays high. A change at cycle 25 is not reported, while a pending record from cycle 19 is still delivered.
